// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port RV32 integer register file with pending-write scoreboard
// Optional same-edge write-to-read forwarding: REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD-1:0]       rd_en_i,
  input  logic [NRD*AW-1:0]    rd_addr_i,
  output logic [NRD*XLEN-1:0]  rd_data_o,
  output logic [NRD-1:0]       rd_busy_o,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*AW-1:0]    wr_addr_i,
  input  logic [NWR*XLEN-1:0]  wr_data_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_addr_i,
  output logic [NREGS-1:0]     busy_o
);

  logic [XLEN-1:0]     mem_q [NREGS];
  logic [XLEN-1:0]     mem_d [NREGS];
  logic [NREGS-1:0]    wr_hit;
  logic [NREGS-1:0]    busy_q, busy_d;
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]      rd_busy_q, rd_busy_d;

  // Higher-numbered write ports are applied last, so they win on a shared address.
  always_comb begin
    wr_hit = '0;
    for (int n = 0; n < NREGS; n++) begin
      mem_d[n] = mem_q[n];
      for (int w = 0; w < NWR; w++) begin
        if ((n != 0) && wr_en_i[w] && (wr_addr_i[w*AW +: AW] == AW'(n))) begin
          mem_d[n]  = wr_data_i[w*XLEN +: XLEN];
          wr_hit[n] = 1'b1;
        end
      end
    end
  end

  // Reserve is applied after the write clear: a new producer outranks the retiring one.
  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (rsv_en_i && (rsv_addr_i != '0)) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int k = 0; k < NRD; k++) begin
      if (rd_en_i[k]) begin
`ifdef REGFILE_BYPASS_EN
        rd_data_d[k*XLEN +: XLEN] = mem_d[rd_addr_i[k*AW +: AW]];
`else
        rd_data_d[k*XLEN +: XLEN] = mem_q[rd_addr_i[k*AW +: AW]];
`endif
        rd_busy_d[k] = busy_q[rd_addr_i[k*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NREGS; n++) begin
        mem_q[n] <= '0;
      end
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int n = 0; n < NREGS; n++) begin
        mem_q[n] <= mem_d[n];
      end
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_busy_o = rd_busy_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic [NRD-1:0]      rd_en_i;
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic [NWR-1:0]      wr_en_i;
  logic [NWR*AW-1:0]   wr_addr_i;
  logic [NWR*XLEN-1:0] wr_data_i;
  logic                rsv_en_i;
  logic [AW-1:0]       rsv_addr_i;
  logic [NREGS-1:0]    busy_o;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en_i    (rd_en_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic        rsv;
    logic [4:0]  rsa;
    logic [31:0] ed0, ed1;
    logic [1:0]  eb;
    logic [31:0] ebusy;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mkv(input int unsigned we, wa0, wd0, wa1, wd1,
                               input int unsigned re, ra0, ra1, rsv, rsa,
                               input int unsigned ed0, ed1, eb, ebusy);
    vec_t v;
    v.we = 2'(we);   v.wa0 = 5'(wa0); v.wd0 = 32'(wd0); v.wa1 = 5'(wa1); v.wd1 = 32'(wd1);
    v.re = 2'(re);   v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
    v.rsv = 1'(rsv); v.rsa = 5'(rsa);
    v.ed0 = 32'(ed0); v.ed1 = 32'(ed1); v.eb = 2'(eb); v.ebusy = 32'(ebusy);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wr_en_i    = v.we;
    wr_addr_i  = {v.wa1, v.wa0};
    wr_data_i  = {v.wd1, v.wd0};
    rd_en_i    = v.re;
    rd_addr_i  = {v.ra1, v.ra0};
    rsv_en_i   = v.rsv;
    rsv_addr_i = v.rsa;
  endtask

  task automatic idle();
    drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic check_all(input string tag, input logic [31:0] d0, d1,
                           input logic [1:0] b, input logic [31:0] bv);
    chk({tag, "_rd_data0"}, rd_data_o[31:0], d0);
    chk({tag, "_rd_data1"}, rd_data_o[63:32], d1);
    chk({tag, "_rd_busy"}, {30'd0, rd_busy_o}, {30'd0, b});
    chk({tag, "_busy_o"}, busy_o, bv);
  endtask

  initial begin
    vt[0]  = mkv(3, 3, 'h11, 3, 'h22,  0, 0, 0,  0, 0,  0, 0, 0, 0);
    vt[1]  = mkv(3, 4, 'h33, 7, 'h44,  3, 3, 0,  0, 0,  'h22, 0, 0, 0);
    vt[2]  = mkv(0, 0, 0, 0, 0,        3, 4, 7,  0, 0,  'h33, 'h44, 0, 0);
    vt[3]  = mkv(1, 2, 'h55, 0, 0,     0, 0, 0,  0, 0,  'h33, 'h44, 0, 0);
    vt[4]  = mkv(0, 0, 0, 0, 0,        1, 2, 0,  0, 0,  'h55, 'h44, 0, 0);
    vt[5]  = mkv(1, 2, 'h66, 0, 0,     0, 2, 2,  0, 0,  'h55, 'h44, 0, 0);
    vt[6]  = mkv(0, 0, 0, 0, 0,        0, 2, 2,  0, 0,  'h55, 'h44, 0, 0);
    vt[7]  = mkv(0, 0, 0, 0, 0,        1, 2, 0,  0, 0,  'h66, 'h44, 0, 0);
    vt[8]  = mkv(0, 0, 0, 0, 0,        0, 0, 0,  1, 6,  'h66, 'h44, 0, 'h40);
    vt[9]  = mkv(0, 0, 0, 0, 0,        3, 6, 6,  0, 0,  0, 0, 3, 'h40);
    vt[10] = mkv(2, 0, 0, 6, 'h77,     1, 6, 0,  0, 0,  BYP ? 'h77 : 0, 0, 3, 0);
    vt[11] = mkv(1, 6, 'h88, 0, 0,     0, 0, 0,  1, 6,  BYP ? 'h77 : 0, 0, 3, 'h40);
    vt[12] = mkv(3, 0, 'hFFFFFFFF, 0, 'hFFFFFFFF, 3, 0, 0, 1, 0, 0, 0, 0, 'h40);
    vt[13] = mkv(0, 0, 0, 0, 0,        3, 0, 0,  0, 0,  0, 0, 0, 'h40);
    vt[14] = mkv(1, 9, 'hA, 0, 0,      0, 0, 0,  0, 0,  0, 0, 0, 'h40);
    vt[15] = mkv(2, 0, 0, 9, 'hB,      1, 9, 0,  0, 0,  BYP ? 'hB : 'hA, 0, 0, 'h40);
    vt[16] = mkv(0, 0, 0, 0, 0,        1, 9, 0,  0, 0,  'hB, 0, 0, 'h40);
    vt[17] = mkv(0, 0, 0, 0, 0,        2, 0, 6,  0, 0,  'hB, 'h88, 2, 'h40);

    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i]);
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vt[i].ed0, vt[i].ed1, vt[i].eb, vt[i].ebusy);
    end

    // Mid-cycle asynchronous reset with a write in flight.
    @(negedge clk);
    drive(mkv(1, 5, 'hDEADBEEF, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0));
    @(negedge clk);
    drive(mkv(0, 0, 0, 0, 0, 3, 5, 5, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_all("pre_rst", 'hDEADBEEF, 'hDEADBEEF, 3, 'h60);
    @(negedge clk);
    drive(mkv(1, 5, 'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("rst_held", 0, 0, 0, 0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    drive(mkv(0, 0, 0, 0, 0, 3, 5, 5, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_all("post_rst", 0, 0, 0, 0);
    @(negedge clk);
    drive(mkv(1, 5, 'h0BADF00D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mkv(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_all("first_wr", 'h0BADF00D, 0, 0, 0);
    @(negedge clk);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RV32 core; successor to the single-write, two-read register file. Provides NRD synchronous read ports, NWR write ports with a fixed priority rule, a hard-wired zero register and a per-register pending-write scoreboard for the issue stage. Sits between decode/issue (read, reserve) and writeback (write).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, register count; power of two, 2..64; AW = $clog2(NREGS)
- NRD, 2, read ports, 1..4
- NWR, 2, write ports, 1..2
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- rd_en_i  input  NRD  per-port read enable
- rd_addr_i  input  NRD*AW  read addresses; port k at [k*AW +: AW]
- rd_data_o  output  NRD*XLEN  registered read data; port k at [k*XLEN +: XLEN]
- rd_busy_o  output  NRD  registered scoreboard bit of the address read
- wr_en_i  input  NWR  per-port write enable
- wr_addr_i  input  NWR*AW  write addresses
- wr_data_i  input  NWR*XLEN  write data
- rsv_en_i  input  1  mark rsv_addr_i as pending
- rsv_addr_i  input  AW  register to reserve
- busy_o  output  NREGS  live scoreboard vector, bit n = register n pending

## Operation
- Storage: NREGS x XLEN array; register 0 exists but is never written, always reads 0, never pending.
- Write: on clk, for each port w with wr_en_i[w] and address != 0, write wr_data_i. Both ports to same address: port 1 wins. Write to address 0 ignored.
- Read: on clk, for each port k with rd_en_i[k]: rd_data_o[k] <= value of addr; rd_busy_o[k] <= scoreboard bit. rd_en_i[k]=0: both outputs hold previous value. Address 0 yields 0 / not busy regardless of enable timing.
- Read and write in the same cycle: reads are independent of write enable (no read stall during writes); data returned per Configuration.
- Scoreboard: rsv_en_i sets bit rsv_addr_i; any write to address n clears bit n. Same-cycle reserve and write to same n: bit set (reserve wins, new producer). Reserve of 0 ignored.
- rd_busy_o reflects scoreboard state before the same-cycle update (old state), independent of the bypass macro.
- Unused upper address bits do not exist (NREGS is a power of two); no wrap handling needed.

## Timing
- Read latency 1 cycle: address at edge N, data valid after edge N, stable until next enabled read.
- Write visible to a read issued at the following edge (N+1) without bypass; same edge with bypass.
- busy_o updates combinationally from state after each edge (registered state, no input path).
- Reset (async assert, any time, including mid-write): array, rd_data_o, rd_busy_o, busy_o all 0 immediately; write in flight at assertion is lost. First write accepted on the first rising edge after deassertion.

## Configuration
- REGFILE_BYPASS_EN defined: read at edge N to address written at edge N returns the winning write data (port 1 over port 0); address 0 still returns 0.
- Undefined: such a read returns the pre-write array value; no forwarding muxes synthesised.

## Test plan
- Reset: write x5=0xDEADBEEF, assert rst_n=0 mid-cycle -> rd_data_o, busy_o all 0 at once; read x5 after release -> 0.
- Zero register: write x0=0xFFFFFFFF, reserve x0, read x0 on all ports -> data 0, rd_busy_o 0, busy_o[0]=0.
- Dual-write conflict: port0 x3=0x11, port1 x3=0x22 same cycle; read next cycle -> 0x22; port0 x4=0x33 + port1 x7=0x44 -> both stored.
- Same-cycle read/write: x9 holds 0xA, write 0xB and read x9 at same edge -> 0xB with REGFILE_BYPASS_EN, 0xA without; next read -> 0xB in both.
- Hold: read x2=0x55, then rd_en_i=0 while x2 rewritten to 0x66 -> rd_data_o stays 0x55 until re-enabled.
- Scoreboard: reserve x6 -> busy_o[6]=1, read x6 -> rd_busy_o=1; write x6 -> bit clears; write x6 plus reserve x6 same edge -> bit stays 1.
